// File: rtl/ma_stage_tx_pkg.sv
// Shared constants for the MA stage transmit bridge: bus widths and FSM encodings.
package ma_stage_tx_pkg;

  localparam int MA_PACKET_SIZE = 40;
  localparam int DATA_SIZE      = 16;
  localparam int TX_CNT_W       = 16;

  // Transmit FSM encodings
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SETUP = 2'd1;
  localparam logic [1:0] TX_WAIT  = 2'd2;

endpackage

// File: rtl/ma_stage_tx_hs_sync.sv
// hs_sync: STAGES-deep flop chain that brings a 2-phase handshake level into
// the local clock domain. Shared with the receive-side bridge.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the chain; oldest bit is the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ma_stage_tx.sv
// ma_stage_tx: clocked valid/ready front end feeding the asynchronous MA stage
// through a 2-phase Send/Ack bundled-data port. Packets queue in a small
// circular FIFO; each one is loaded into the bundle registers, held for a full
// setup cycle, then SEND_OUT toggles and the FSM waits for the synchronized ack.
module ma_stage_tx
  import ma_stage_tx_pkg::*;
#(
  parameter int PKT_W       = MA_PACKET_SIZE,
  parameter int DAT_W       = DATA_SIZE,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [PKT_W-1:0]    IN_PKT,
  input  logic [DAT_W-1:0]    IN_WDATA,
  input  logic                IN_WEN,
  input  logic                IN_LOAD,
  output logic                SEND_OUT,
  input  logic                ACK_IN,
  output logic [PKT_W-1:0]    PACKET_OUT,
  output logic [DAT_W-1:0]    WRITE_DATA,
  output logic                WRITE_EN,
  output logic                LOAD_FLG,
  output logic                BUSY,
  output logic [TX_CNT_W-1:0] TX_COUNT,
  output logic                PROTO_ERR
);

  localparam int              AW    = $clog2(DEPTH);
  localparam int              ENT_W = PKT_W + DAT_W + 2;
  localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                fifo_ne, push, pop;
  logic [ENT_W-1:0]    head;

  // Handshake and FSM
  logic [1:0]          state;
  logic                ack_s, ack_s_q, ack_tgl;
  logic [TX_CNT_W-1:0] tx_cnt_q;

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (ACK_IN),
    .q     (ack_s)
  );

  // Each edge of the synchronized ack is one event. Only an event seen in WAIT
  // completes a transfer; events in IDLE/SETUP are flagged and dropped, so a
  // stray toggle cannot later be mistaken for a real acknowledge.
  assign ack_tgl  = ack_s ^ ack_s_q;

  assign fifo_ne  = (count != '0);
  assign IN_READY = (count != FULL);
  assign push     = IN_VALID && IN_READY;
  assign pop      = fifo_ne && ((state == TX_IDLE) || ((state == TX_WAIT) && ack_tgl));
  assign head     = mem[rd_ptr];
  assign BUSY     = (state != TX_IDLE) || fifo_ne;
  assign TX_COUNT = tx_cnt_q;

  // Previous synchronized ack level, for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ack_s_q <= 1'b0;
    else        ack_s_q <= ack_s;
  end

  // FIFO data array; contents are don't-care while the slot is empty
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {IN_PKT, IN_WDATA, IN_WEN, IN_LOAD};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Transmit FSM, bundle registers, completion counter and protocol error flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= TX_IDLE;
      SEND_OUT   <= 1'b0;
      PACKET_OUT <= '0;
      WRITE_DATA <= '0;
      WRITE_EN   <= 1'b0;
      LOAD_FLG   <= 1'b0;
      tx_cnt_q   <= '0;
      PROTO_ERR  <= 1'b0;
    end else begin
      if (ack_tgl && (state != TX_WAIT)) PROTO_ERR <= 1'b1;
      // Bundle only changes on a pop, which always leads into SETUP, so the
      // data is stable for a full cycle before SEND_OUT moves.
      if (pop) {PACKET_OUT, WRITE_DATA, WRITE_EN, LOAD_FLG} <= head;
      case (state)
        TX_IDLE: begin
          if (fifo_ne) state <= TX_SETUP;
        end
        TX_SETUP: begin
          SEND_OUT <= ~SEND_OUT;
          state    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (ack_tgl) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            state    <= fifo_ne ? TX_SETUP : TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_stage_tx.sv
// Bench for ma_stage_tx: directed phases plus a randomized run, checked against
// a queue-based model of the packets that should appear on the bundle in order.
module tb_ma_stage_tx;

  localparam int PKT_W = 40;
  localparam int DAT_W = 16;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [DAT_W-1:0] wd;
    logic             wen;
    logic             ld;
  } ent_t;

  logic             CLK = 1'b0, RST_N = 1'b0;
  logic             IN_VALID = 1'b0, IN_READY;
  logic [PKT_W-1:0] IN_PKT = '0;
  logic [DAT_W-1:0] IN_WDATA = '0;
  logic             IN_WEN = 1'b0, IN_LOAD = 1'b0;
  logic             SEND_OUT, ACK_IN = 1'b0;
  logic [PKT_W-1:0] PACKET_OUT;
  logic [DAT_W-1:0] WRITE_DATA;
  logic             WRITE_EN, LOAD_FLG, BUSY, PROTO_ERR;
  logic [15:0]      TX_COUNT;

  ma_stage_tx #(.PKT_W(PKT_W), .DAT_W(DAT_W), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PKT(IN_PKT), .IN_WDATA(IN_WDATA), .IN_WEN(IN_WEN), .IN_LOAD(IN_LOAD),
    .SEND_OUT(SEND_OUT), .ACK_IN(ACK_IN), .PACKET_OUT(PACKET_OUT),
    .WRITE_DATA(WRITE_DATA), .WRITE_EN(WRITE_EN), .LOAD_FLG(LOAD_FLG),
    .BUSY(BUSY), .TX_COUNT(TX_COUNT), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int          errors = 0, checks = 0;
  ent_t        exp_q[$];
  ent_t        cap;
  logic [15:0] tx_model = '0;
  int          togs = 0;
  logic        prev_send = 1'b0;
  bit          ack_en = 1'b0, stab_en = 1'b0;
  int          ack_dly = 12;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Downstream MA stage: echo SEND_OUT onto ACK_IN after ack_dly
  initial forever begin
    @(posedge CLK);
    if (ack_en && RST_N && (ACK_IN != SEND_OUT)) begin
      #(ack_dly);
      if (ack_en && RST_N) ACK_IN = SEND_OUT;
    end
  end

  // Every SEND_OUT edge must present the oldest accepted packet; bundle held while outstanding
  always @(negedge CLK) begin
    if (RST_N && (SEND_OUT != prev_send)) begin
      togs++;
      if (exp_q.size() == 0) chk("unexpected_send", 64'(1), 64'(0));
      else begin
        cap = exp_q.pop_front();
        chk("bundle_pkt",  64'(PACKET_OUT), 64'(cap.pkt));
        chk("bundle_wd",   64'(WRITE_DATA), 64'(cap.wd));
        chk("bundle_wen",  64'(WRITE_EN),   64'(cap.wen));
        chk("bundle_load", 64'(LOAD_FLG),   64'(cap.ld));
      end
    end else if (RST_N && stab_en && (SEND_OUT != ACK_IN)) begin
      chk("stable_pkt",  64'(PACKET_OUT), 64'(cap.pkt));
      chk("stable_wd",   64'(WRITE_DATA), 64'(cap.wd));
      chk("stable_load", 64'(LOAD_FLG),   64'(cap.ld));
    end
    prev_send = SEND_OUT;
  end

  // Offer one entry for one edge; caller owns IN_VALID deassertion
  task automatic push(input logic [PKT_W-1:0] p, input logic [DAT_W-1:0] w,
                      input logic we, input logic ld, output bit acc);
    ent_t e;
    IN_PKT = p; IN_WDATA = w; IN_WEN = we; IN_LOAD = ld; IN_VALID = 1'b1;
    acc = IN_READY;
    @(posedge CLK);
    if (acc) begin
      e.pkt = p; e.wd = w; e.wen = we; e.ld = ld;
      exp_q.push_back(e);
      tx_model++;
    end
    @(negedge CLK);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!BUSY && (SEND_OUT == ACK_IN) && (exp_q.size() == 0)) begin ok = 1'b1; break; end
    end
    chk("drain_done", 64'(ok), 64'(1));
  endtask

  initial begin
    bit          acc;
    int          tog_base;
    logic [15:0] pkts [6];
    logic [15:0] wds  [6];
    pkts = '{16'd3, 16'd4, 16'd3, 16'd4, 16'd5, 16'd6};
    wds  = '{16'd55555, 16'd11111, 16'd33333, 16'd22222, 16'd12345, 16'd999};

    // Reset state
    wait_cycles(3);
    chk("rst_send",  64'(SEND_OUT),   64'(0));
    chk("rst_pkt",   64'(PACKET_OUT), 64'(0));
    chk("rst_wd",    64'(WRITE_DATA), 64'(0));
    chk("rst_wen",   64'(WRITE_EN),   64'(0));
    chk("rst_load",  64'(LOAD_FLG),   64'(0));
    chk("rst_cnt",   64'(TX_COUNT),   64'(0));
    chk("rst_perr",  64'(PROTO_ERR),  64'(0));
    chk("rst_busy",  64'(BUSY),       64'(0));
    chk("rst_ready", 64'(IN_READY),   64'(1));
    RST_N = 1'b1;
    wait_cycles(2);

    // Single packet: bundle at t+1, SEND_OUT at t+2
    ack_en = 1'b1; ack_dly = 12;
    push(40'd3, 16'd55555, 1'b1, 1'b0, acc);
    IN_VALID = 1'b0;
    chk("lat_t0_send", 64'(SEND_OUT), 64'(0));
    @(negedge CLK);
    chk("lat_t1_send", 64'(SEND_OUT),   64'(0));
    chk("lat_t1_pkt",  64'(PACKET_OUT), 64'(3));
    chk("lat_t1_wd",   64'(WRITE_DATA), 64'(55555));
    @(negedge CLK);
    chk("lat_t2_send", 64'(SEND_OUT), 64'(1));
    drain(200);
    chk("single_cnt", 64'(TX_COUNT), 64'(tx_model));
    chk("single_cnt_abs", 64'(TX_COUNT), 64'(1));

    // Burst with acks held: one in flight plus four queued fills the FIFO
    ack_en = 1'b0;
    tog_base = togs;
    for (int i = 0; i < 5; i++) begin
      push(40'(pkts[i]), wds[i], 1'b1, 1'(i % 2), acc);
      chk("burst_acc", 64'(acc), 64'(1));
    end
    chk("burst_full_ready", 64'(IN_READY), 64'(0));
    push(40'(pkts[5]), wds[5], 1'b0, 1'b0, acc);
    chk("burst_refused", 64'(acc), 64'(0));
    IN_VALID = 1'b0;
    wait_cycles(6);
    chk("burst_one_send", 64'(togs - tog_base), 64'(1));
    ack_en = 1'b1;
    drain(400);
    chk("burst_sends", 64'(togs - tog_base), 64'(5));
    chk("burst_cnt",   64'(TX_COUNT), 64'(tx_model));

    // Slow acks: bundle must stay put while a request is outstanding
    ack_dly = 200; stab_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(40'({$urandom(), $urandom()}), 16'($urandom()), 1'($urandom()), 1'($urandom()), acc);
    end
    IN_VALID = 1'b0;
    drain(2000);
    stab_en = 1'b0;
    chk("slow_cnt", 64'(TX_COUNT), 64'(tx_model));

    // Randomized traffic with varying ack delay
    for (int i = 0; i < 16; i++) begin
      ack_dly = $urandom_range(3, 60);
      push(40'({$urandom(), $urandom()}), 16'($urandom()), 1'($urandom()), 1'($urandom()), acc);
      IN_VALID = 1'b0;
      wait_cycles($urandom_range(0, 3));
    end
    drain(3000);
    chk("rand_cnt", 64'(TX_COUNT), 64'(tx_model));

    // Spurious ack toggles while idle: flagged, FSM stays idle
    ack_en = 1'b0; ack_dly = 12;
    tog_base = togs;
    ACK_IN = ~ACK_IN;
    wait_cycles(6);
    chk("spur_perr", 64'(PROTO_ERR), 64'(1));
    chk("spur_busy", 64'(BUSY), 64'(0));
    ACK_IN = ~ACK_IN;
    wait_cycles(6);
    chk("spur_busy2", 64'(BUSY), 64'(0));
    chk("spur_nosend", 64'(togs - tog_base), 64'(0));
    ack_en = 1'b1;
    push(40'h12_3456_789A, 16'd777, 1'b1, 1'b1, acc);
    IN_VALID = 1'b0;
    drain(200);
    chk("spur_cnt", 64'(TX_COUNT), 64'(tx_model));
    chk("spur_perr_sticky", 64'(PROTO_ERR), 64'(1));

    // Reset in WAIT with two packets still queued
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(40'(i + 10), 16'(i), 1'b1, 1'b0, acc);
    IN_VALID = 1'b0;
    wait_cycles(3);
    chk("pre_rst_busy", 64'(BUSY), 64'(1));
    RST_N = 1'b0; ACK_IN = 1'b0;
    #1;
    chk("mid_rst_send",  64'(SEND_OUT), 64'(0));
    chk("mid_rst_busy",  64'(BUSY),     64'(0));
    chk("mid_rst_ready", 64'(IN_READY), 64'(1));
    chk("mid_rst_perr",  64'(PROTO_ERR), 64'(0));
    exp_q.delete();
    tx_model = '0;
    wait_cycles(2);
    RST_N = 1'b1;
    wait_cycles(1);
    ack_en = 1'b1;
    push(40'hAB_CDEF_0123, 16'd44444, 1'b0, 1'b1, acc);
    IN_VALID = 1'b0;
    drain(200);
    chk("post_rst_cnt", 64'(TX_COUNT), 64'(1));

    // Counter wrap
    force dut.tx_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.tx_cnt_q;
    tx_model = 16'hFFFF;
    chk("wrap_pre", 64'(TX_COUNT), 64'(16'hFFFF));
    push(40'd42, 16'd1, 1'b1, 1'b0, acc);
    IN_VALID = 1'b0;
    drain(200);
    chk("wrap_cnt", 64'(TX_COUNT), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    chk("watchdog", 64'(0), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
